// File: rtl/mont_mul.sv
// Radix-2 bit-serial Montgomery multiplier: R = A*B*2^-N mod M.
// Operands are latched on acceptance; one multiplier bit is consumed per LOOP cycle.
module mont_mul #(
  parameter int N = 448
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] M,
  output logic [N-1:0] R,
  input  logic         req_valid,
  output logic         req_ready,
  output logic         req_busy,
  output logic         res_valid,
  input  logic         res_ready
);

  // state | meaning
  // IDLE  | waiting for req_valid; operands latched on acceptance
  // READY | clear accumulator and iteration counter
  // LOOP  | one Montgomery iteration per cycle, A bits LSB first
  // FINAL | conditional subtraction, load R, raise res_valid
  // POST  | hold R/res_valid until res_ready

  localparam int CW = $clog2(N + 1);
  localparam int SW = N + 2;
  localparam int TW = N + 3;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {IDLE, READY, LOOP, FINAL, POST} state_t;

  state_t        state;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  m_q;
  logic [SW-1:0] s_q;
  logic [CW-1:0] cnt;

  logic [TW-1:0] sum_ab;
  logic [TW-1:0] sum_m;
  logic [SW-1:0] s_next;
  logic [N-1:0]  r_next;

  // One extra bit of headroom in the sum keeps out-of-range operands from
  // corrupting the shift; legal operands never use it.
  always_comb begin
    sum_ab = {1'b0, s_q} + (a_q[0] ? {3'b000, b_q} : {TW{1'b0}});
    sum_m  = sum_ab[0] ? sum_ab + {3'b000, m_q} : sum_ab;
    s_next = SW'(sum_m >> 1);
    r_next = N'((s_q >= {2'b00, m_q}) ? s_q - {2'b00, m_q} : s_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      req_busy  <= 1'b0;
      res_valid <= 1'b0;
      R         <= '0;
      s_q       <= '0;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      m_q       <= '0;
    end else begin
      req_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q       <= A;
            b_q       <= B;
            m_q       <= M;
            req_ready <= 1'b1;
            req_busy  <= 1'b1;
            state     <= READY;
          end
        end
        READY: begin
          s_q   <= '0;
          cnt   <= '0;
          state <= LOOP;
        end
        LOOP: begin
          s_q <= s_next;
          a_q <= a_q >> 1;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= FINAL;
        end
        FINAL: begin
          R         <= r_next;
          res_valid <= 1'b1;
          req_busy  <= 1'b0;
          state     <= POST;
        end
        POST: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mul.sv
// Directed bench for mont_mul: an N=8 instance for handshake/reset scenarios
// and an N=448 instance for the wide-modulus vectors.
module tb_mont_mul;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0] a8, b8, m8, r8;
  logic       rv8, rr8, busy8, resv8, resr8;

  logic [447:0] aw, bw, mw, rw;
  logic         rvw, rrw, busyw, resvw, resrw;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mont_mul #(.N(8)) u8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .M(m8), .R(r8),
    .req_valid(rv8), .req_ready(rr8), .req_busy(busy8),
    .res_valid(resv8), .res_ready(resr8)
  );

  mont_mul #(.N(448)) u448 (
    .clk(clk), .rst(rst), .A(aw), .B(bw), .M(mw), .R(rw),
    .req_valid(rvw), .req_ready(rrw), .req_busy(busyw),
    .res_valid(resvw), .res_ready(resrw)
  );

  // Drives one N=8 request and consumes its result; lat counts cycles from
  // the req_ready pulse to res_valid (-1 on timeout).
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                        output logic [7:0] r, output int lat);
    int w;
    @(negedge clk);
    a8 = a; b8 = b; m8 = m; rv8 = 1'b1; resr8 = 1'b0;
    w = 0;
    do begin @(negedge clk); w++; end while (!rr8 && w < 10);
    rv8 = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resv8 && lat < 50);
    if (!resv8) lat = -1;
    r = r8;
    resr8 = 1'b1;
    @(negedge clk);
    resr8 = 1'b0;
  endtask

  task automatic do_opw(input logic [447:0] a, input logic [447:0] b, input logic [447:0] m,
                        output logic [447:0] r, output int lat);
    int w;
    @(negedge clk);
    aw = a; bw = b; mw = m; rvw = 1'b1; resrw = 1'b0;
    w = 0;
    do begin @(negedge clk); w++; end while (!rrw && w < 10);
    rvw = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resvw && lat < 600);
    if (!resvw) lat = -1;
    r = rw;
    resrw = 1'b1;
    @(negedge clk);
    resrw = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rv8 = 1'b0; resr8 = 1'b0; rvw = 1'b0; resrw = 1'b0;
    a8 = '0; b8 = '0; m8 = '0; aw = '0; bw = '0; mw = '0;
    repeat (3) @(negedge clk);
    total_cnt++; if (rr8 !== 1'b0) $display("FAIL reset_req_ready got %b want 0", rr8); else pass_cnt++;
    total_cnt++; if (busy8 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy8); else pass_cnt++;
    total_cnt++; if (resv8 !== 1'b0) $display("FAIL reset_res_valid got %b want 0", resv8); else pass_cnt++;
    total_cnt++; if (r8 !== 8'd0) $display("FAIL reset_R got %0d want 0", r8); else pass_cnt++;
    total_cnt++; if (resvw !== 1'b0) $display("FAIL reset_wide_res_valid got %b want 0", resvw); else pass_cnt++;
    total_cnt++; if (rw !== 448'd0) $display("FAIL reset_wide_R got %h want 0", rw); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] r;
    int lat;
    do_op8(8'd5, 8'd100, 8'd251, r, lat);
    total_cnt++; if (r !== 8'd100) $display("FAIL basic_R got %0d want 100", r); else pass_cnt++;
    total_cnt++; if (lat != 10) $display("FAIL basic_latency got %0d want 10", lat); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if (r8 !== 8'd100) $display("FAIL basic_R_hold got %0d want 100", r8); else pass_cnt++;
    total_cnt++; if (resv8 !== 1'b0 || busy8 !== 1'b0)
      $display("FAIL basic_idle_flags got valid=%b busy=%b want 0/0", resv8, busy8); else pass_cnt++;
  endtask

  task automatic test_vectors;
    logic [7:0] va [4] = '{8'd250, 8'd0,   8'd7,   8'd1};
    logic [7:0] vb [4] = '{8'd250, 8'd123, 8'd100, 8'd1};
    logic [7:0] ve [4] = '{8'd201, 8'd0,   8'd140, 8'd201};
    logic [7:0] r;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op8(va[i], vb[i], 8'd251, r, lat);
      total_cnt++; if (r !== ve[i]) $display("FAIL vector%0d_R got %0d want %0d", i, r, ve[i]); else pass_cnt++;
      total_cnt++; if (lat != 10) $display("FAIL vector%0d_latency got %0d want 10", i, lat); else pass_cnt++;
    end
  endtask

  task automatic test_bad_precond;
    logic [7:0] r;
    int lat;
    do_op8(8'd3, 8'd4, 8'd250, r, lat);
    total_cnt++; if (lat != 10) $display("FAIL even_m_latency got %0d want 10", lat); else pass_cnt++;
    total_cnt++; if (resv8 !== 1'b0 || busy8 !== 1'b0)
      $display("FAIL even_m_handshake got valid=%b busy=%b want 0/0", resv8, busy8); else pass_cnt++;
  endtask

  task automatic test_wide;
    logic [447:0] m, a, r;
    logic [451:0] t;
    int lat;
    m = ~(448'd1 << 224);
    a = (448'd3 << 224) + 448'd2;
    do_opw(a, 448'd1, m, r, lat);
    total_cnt++; if (r !== (448'd1 << 224) + 448'd1) $display("FAIL wide_r2_R got %h", r); else pass_cnt++;
    total_cnt++; if (lat != 450) $display("FAIL wide_r2_latency got %0d want 450", lat); else pass_cnt++;
    t = ((452'd2 << 448) - (452'd1 << 224) - 452'd1) / 452'd9;
    a = t[447:0];
    do_opw(a, 448'd9, m, r, lat);
    total_cnt++; if (r !== 448'd1) $display("FAIL wide_inv9_R got %h want 1", r); else pass_cnt++;
    total_cnt++; if (lat != 450) $display("FAIL wide_inv9_latency got %0d want 450", lat); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [7:0] r;
    int lat;
    logic seen;
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd100; m8 = 8'd251; rv8 = 1'b1; resr8 = 1'b0;
    @(negedge clk);
    rv8 = 1'b0;
    total_cnt++; if (rr8 !== 1'b1) $display("FAIL abort_accept got %b want 1", rr8); else pass_cnt++;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++; if (rr8 !== 1'b0 || busy8 !== 1'b0 || resv8 !== 1'b0 || r8 !== 8'd0)
      $display("FAIL abort_outputs got ready=%b busy=%b valid=%b R=%0d want 0/0/0/0", rr8, busy8, resv8, r8);
    else pass_cnt++;
    seen = 1'b0;
    repeat (15) begin @(negedge clk); if (resv8) seen = 1'b1; end
    total_cnt++; if (seen !== 1'b0) $display("FAIL abort_no_result got %b want 0", seen); else pass_cnt++;
    do_op8(8'd5, 8'd100, 8'd251, r, lat);
    total_cnt++; if (r !== 8'd100) $display("FAIL abort_next_R got %0d want 100", r); else pass_cnt++;
    total_cnt++; if (lat != 10) $display("FAIL abort_next_latency got %0d want 10", lat); else pass_cnt++;
  endtask

  task automatic test_hold_back_to_back;
    int lat;
    logic stable;
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd100; m8 = 8'd251; rv8 = 1'b1; resr8 = 1'b0;
    @(negedge clk);
    total_cnt++; if (rr8 !== 1'b1 || busy8 !== 1'b1)
      $display("FAIL hold_accept got ready=%b busy=%b want 1/1", rr8, busy8); else pass_cnt++;
    a8 = 8'd7;
    @(negedge clk);
    total_cnt++; if (rr8 !== 1'b0) $display("FAIL hold_ready_pulse got %b want 0", rr8); else pass_cnt++;
    lat = 1;
    while (!resv8 && lat < 50) begin @(negedge clk); lat++; end
    total_cnt++; if (lat != 10) $display("FAIL hold_latency got %0d want 10", lat); else pass_cnt++;
    total_cnt++; if (r8 !== 8'd100) $display("FAIL hold_latched_A got %0d want 100", r8); else pass_cnt++;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (resv8 !== 1'b1 || r8 !== 8'd100 || rr8 !== 1'b0) stable = 1'b0;
    end
    total_cnt++; if (stable !== 1'b1) $display("FAIL hold_post_stable got %b want 1", stable); else pass_cnt++;
    resr8 = 1'b1;
    @(negedge clk);
    resr8 = 1'b0;
    total_cnt++; if (resv8 !== 1'b0 || rr8 !== 1'b0)
      $display("FAIL hold_post_exit got valid=%b ready=%b want 0/0", resv8, rr8); else pass_cnt++;
    @(negedge clk);
    rv8 = 1'b0;
    total_cnt++; if (rr8 !== 1'b1) $display("FAIL b2b_accept got %b want 1", rr8); else pass_cnt++;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resv8 && lat < 50);
    total_cnt++; if (r8 !== 8'd140 || lat != 10)
      $display("FAIL b2b_result got R=%0d lat=%0d want 140/10", r8, lat); else pass_cnt++;
    resr8 = 1'b1;
    @(negedge clk);
    resr8 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_vectors;
    test_bad_precond;
    test_reset_mid;
    test_hold_back_to_back;
    test_wide;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
